mul_seq: RTL and testbench
==========================

# mul_seq

Parametrised sequential shift-add multiplier, the generalised successor of the 4×4 sequential multiplier. It computes one WIDTH×WIDTH product per request, unsigned or two's-complement signed, selectable per operation, with a fixed latency of WIDTH cycles. It sits behind a START/DONE handshake, adds a BUSY status output, and holds the result stable until the next completion. Each datapath unit that needs a multiply without a combinational array multiplier instantiates one.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..16; result width is 2*WIDTH.
- CLK  input  1  rising-edge clock, the only clock.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  request; sampled on a rising edge, accepted only when BUSY=0.
- SIGNED  input  1  0 = unsigned, 1 = two's-complement signed; sampled with START.
- A  input  WIDTH  multiplicand; sampled with START.
- B  input  WIDTH  multiplier; sampled with START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse marking completion.
- Y  output  2*WIDTH  product; held between completions.

## Operation
- FSM states: IDLE and RUN.
- IDLE -> RUN when START=1 at the edge:
  - latch A, B and SIGNED;
  - clear the 2*WIDTH accumulator;
  - load the iteration counter with 0.
- RUN, one iteration per edge, bit i = B[i] (LSB first), for i = 0..WIDTH-1:
  - if B[i]=1, add A shifted left by i into the accumulator;
  - in signed mode, sign-extend A to 2*WIDTH before shifting;
  - in signed mode with i = WIDTH-1, subtract instead of add (MSB weight is -2^(WIDTH-1)).
- Accumulator arithmetic is modulo 2^(2*WIDTH); the true product always fits in 2*WIDTH bits, so there is no overflow flag.
- On the edge completing iteration WIDTH-1:
  - the FSM returns to IDLE;
  - Y is loaded with the final accumulator value;
  - DONE is set for exactly one cycle.
- Y changes only on a completion edge or on reset. Internal iteration never disturbs Y.
- START with BUSY=1 is ignored. A, B and SIGNED may change freely during RUN without effect.
- START in the DONE cycle is accepted, since the FSM is already in IDLE. Back-to-back operations need no gap cycle.
- RST=1 at any edge, including mid-RUN:
  - state goes to IDLE, the counter and accumulator clear;
  - BUSY=0, DONE=0, Y=0;
  - the in-flight operation is discarded and no DONE is produced for it;
  - RST has priority over START at the same edge.

## Timing
- Reset values: BUSY=0, DONE=0, Y=0, state IDLE.
- START accepted at edge E0:
  - BUSY=1 after E0;
  - DONE=0 after each of edges E1..E(WIDTH-1);
  - after edge E(WIDTH): DONE=1, BUSY=0, Y valid;
  - after edge E(WIDTH+1): DONE=0, unless a new operation completes there, which is impossible for WIDTH≥2.
- Latency is always WIDTH cycles, independent of operand values. There is no early termination for zero operands.
- BUSY is high for exactly WIDTH cycles per operation.
- Throughput with back-to-back START: one result every WIDTH cycles.
- WIDTH=4 example: START seen at E0. DONE is low 3 periods after the cycle following E0, and high at 4 periods after E0.

## Test plan
- WIDTH=4, unsigned: 1×1, then 5×4, each a one-cycle START.
  - Required: Y=1, then Y=20.
  - DONE high exactly one cycle each; BUSY falls together with DONE rising.
- WIDTH=4, unsigned, 10×10, exact timing:
  - DONE=0 after E1..E3; DONE=1 and Y=100 after E4; DONE=0 after E5.
  - 15×15 gives Y=225.
- WIDTH=4, signed:
  - -3×5 gives Y=8'hF1;
  - -8×-8 gives Y=8'h40;
  - 7×-1 gives Y=8'hF9;
  - unsigned 4'hD×4'h5 right after -3×5 gives Y=65, which confirms SIGNED is latched per operation.
- START pulse with new operands at E2 of a running 3×3:
  - the second request is ignored;
  - Y=9 with the original latency;
  - only one DONE pulse.
- Back-to-back: START held in the DONE cycle of 2×3, with operands 4×4 presented in that cycle.
  - Y=6 at the first DONE.
  - Y=16 exactly 4 cycles later.
  - Y stays 6 in the cycles between the two DONEs.
- Reset and WIDTH=8:
  - RST asserted at E2 of a running operation gives BUSY=0, DONE=0, Y=0 after that edge; no DONE follows.
  - WIDTH=8, unsigned 255×255 gives Y=65025 after E8.
  - WIDTH=8, signed -128×-128 gives Y=16384.

Source files
------------

// File: rtl/mul_seq_if.sv
// mul_seq_if: request/response bundle for the sequential multiplier.
//
// Handshake: the master raises START together with SIGNED/A/B; the request is
// taken on the rising edge where the slave shows BUSY=0. BUSY stays high for
// the whole run. DONE is a one-cycle pulse on which Y carries the new product.
// Y is held until the next DONE.
//
// Signals:
//   START  - request strobe (master -> slave)
//   SIGNED - 0 unsigned, 1 two's-complement (master -> slave)
//   A, B   - WIDTH-bit operands (master -> slave)
//   BUSY   - operation in progress (slave -> master)
//   DONE   - completion pulse (slave -> master)
//   Y      - 2*WIDTH-bit product (slave -> master)
interface mul_seq_if #(
    parameter int WIDTH = 4
);
    logic                 START;
    logic                 SIGNED;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   Y;

    modport master (
        output START, SIGNED, A, B,
        input  BUSY, DONE, Y
    );

    modport slave (
        input  START, SIGNED, A, B,
        output BUSY, DONE, Y
    );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//
// One multiplier bit is consumed per clock, LSB first, so every operation
// takes exactly WIDTH cycles regardless of operand values. In signed mode the
// multiplicand is sign-extended and the multiplier MSB carries weight
// -2^(WIDTH-1), so that partial product is subtracted instead of added.
//
// Ports:
//   CLK     - rising-edge clock
//   RST     - synchronous active-high reset (priority over START)
//   bus     - mul_seq_if slave: START/SIGNED/A/B in, BUSY/DONE/Y out
//   dbg_run - FSM state for observation: 0 = IDLE, 1 = RUN
module mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    mul_seq_if.slave    bus,
    output logic        dbg_run
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     a_shift;
    logic [PW-1:0]     acc_next;
    logic              last_iter;

    always_comb begin
        // Extension choice follows the latched mode, not the live SIGNED input.
        a_ext     = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        a_shift   = a_ext << cnt_q;
        last_iter = (cnt_q == CW'(WIDTH - 1));

        acc_next = acc_q;
        if (b_q[cnt_q]) begin
            // Signed MSB has negative weight: subtract its partial product.
            if (sgn_q && last_iter) begin
                acc_next = acc_q - a_shift;
            end else begin
                acc_next = acc_q + a_shift;
            end
        end

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sgn_d   = bus.SIGNED;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                if (last_iter) begin
                    // Y is only written here, so iteration never disturbs it.
                    y_d     = acc_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.Y    = y_q;
    assign dbg_run  = (state_q == RUN);
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed bench for mul_seq at WIDTH=4 and WIDTH=8.
// A cycle-level model (remaining-cycle count plus an arithmetic product) is
// compared against both DUTs every cycle; directed sequences add literal
// expectations for products, timing and reset behaviour.
module tb_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_seq_if #(.WIDTH(4)) bus4 ();
    mul_seq_if #(.WIDTH(8)) bus8 ();
    logic dbg4, dbg8;

    mul_seq #(.WIDTH(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4.slave), .dbg_run(dbg4));
    mul_seq #(.WIDTH(8)) dut8 (.CLK(clk), .RST(rst), .bus(bus8.slave), .dbg_run(dbg8));

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product straight from the arithmetic definition.
    function automatic logic [31:0] product(int w, bit sgn, logic [15:0] a, logic [15:0] b);
        longint ai = longint'(a);
        longint bi = longint'(b);
        longint mask;
        if (sgn && a[w-1]) ai = ai - (longint'(1) << w);
        if (sgn && b[w-1]) bi = bi - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        return 32'((ai * bi) & mask);
    endfunction

    // Model: an accepted request completes exactly w edges later.
    int          m_left [2];
    bit          m_done [2];
    logic [31:0] m_y    [2];
    logic [31:0] m_pend [2];

    task automatic model_step(int k, int w, bit start, bit sgn, logic [15:0] a, logic [15:0] b);
        if (rst) begin
            m_left[k] = 0;
            m_done[k] = 1'b0;
            m_y[k]    = '0;
        end else begin
            m_done[k] = 1'b0;
            if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_done[k] = 1'b1;
                    m_y[k]    = m_pend[k];
                end
            end else if (start) begin
                m_left[k] = w;
                m_pend[k] = product(w, sgn, a, b);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 4, bus4.START, bus4.SIGNED, 16'(bus4.A), 16'(bus4.B));
        model_step(1, 8, bus8.START, bus8.SIGNED, 16'(bus8.A), 16'(bus8.B));
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy4", 32'(bus4.BUSY), 32'(m_left[0] > 0));
            check("cmp_run4",  32'(dbg4),      32'(m_left[0] > 0));
            check("cmp_done4", 32'(bus4.DONE), 32'(m_done[0]));
            check("cmp_y4",    32'(bus4.Y),    m_y[0]);
            check("cmp_busy8", 32'(bus8.BUSY), 32'(m_left[1] > 0));
            check("cmp_run8",  32'(dbg8),      32'(m_left[1] > 0));
            check("cmp_done8", 32'(bus8.DONE), 32'(m_done[1]));
            check("cmp_y8",    32'(bus8.Y),    m_y[1]);
        end
    end

    // Present a one-cycle START at the current negedge; returns after the accept edge.
    task automatic go(int which, bit s, logic [7:0] a, logic [7:0] b);
        if (which == 0) begin
            bus4.START = 1'b1; bus4.SIGNED = s; bus4.A = a[3:0]; bus4.B = b[3:0];
        end else begin
            bus8.START = 1'b1; bus8.SIGNED = s; bus8.A = a; bus8.B = b;
        end
        @(negedge clk);
        bus4.START = 1'b0;
        bus8.START = 1'b0;
    endtask

    // Wait (bounded) for DONE, then check the product; n returns negedges waited.
    task automatic wait_done(int which, string name, logic [31:0] exp, output int n);
        logic d;
        n = 0;
        d = (which == 0) ? bus4.DONE : bus8.DONE;
        while (!d && n < 20) begin
            @(negedge clk);
            n++;
            d = (which == 0) ? bus4.DONE : bus8.DONE;
        end
        if (!d) begin
            check({name, "_timeout"}, 32'(0), 32'(1));
        end else if (which == 0) begin
            check(name, 32'(bus4.Y), exp);
            check({name, "_busy"}, 32'(bus4.BUSY), 32'(0));
        end else begin
            check(name, 32'(bus8.Y), exp);
            check({name, "_busy"}, 32'(bus8.BUSY), 32'(0));
        end
    endtask

    initial begin
        int n;
        int cnt;
        bus4.START = 1'b0; bus4.SIGNED = 1'b0; bus4.A = '0; bus4.B = '0;
        bus8.START = 1'b0; bus8.SIGNED = 1'b0; bus8.A = '0; bus8.B = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy4", 32'(bus4.BUSY), 32'(0));
        check("rst_done4", 32'(bus4.DONE), 32'(0));
        check("rst_y4",    32'(bus4.Y),    32'(0));
        check("rst_y8",    32'(bus8.Y),    32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Unsigned basics
        go(0, 0, 8'd1, 8'd1);  wait_done(0, "u_1x1", 32'd1, n);
        go(0, 0, 8'd5, 8'd4);  wait_done(0, "u_5x4", 32'd20, n);

        // Exact timing of 10x10
        go(0, 0, 8'd10, 8'd10);
        check("t_busy_e0", 32'(bus4.BUSY), 32'(1));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t_done_low", 32'(bus4.DONE), 32'(0));
        end
        @(negedge clk);
        check("t_done_e4", 32'(bus4.DONE), 32'(1));
        check("t_y_e4",    32'(bus4.Y),    32'd100);
        check("t_busy_e4", 32'(bus4.BUSY), 32'(0));
        @(negedge clk);
        check("t_done_e5", 32'(bus4.DONE), 32'(0));

        go(0, 0, 8'd15, 8'd15); wait_done(0, "u_15x15", 32'd225, n);

        // Signed, then unsigned to show SIGNED is latched per operation
        go(0, 1, 8'hD, 8'h5);  wait_done(0, "s_m3x5",  32'hF1, n);
        go(0, 0, 8'hD, 8'h5);  wait_done(0, "u_13x5",  32'd65, n);
        go(0, 1, 8'h8, 8'h8);  wait_done(0, "s_m8xm8", 32'h40, n);
        go(0, 1, 8'h7, 8'hF);  wait_done(0, "s_7xm1",  32'hF9, n);

        // START during RUN is ignored
        go(0, 0, 8'd3, 8'd3);
        @(negedge clk);
        bus4.START = 1'b1; bus4.A = 4'd5; bus4.B = 4'd5;
        @(negedge clk);
        bus4.START = 1'b0;
        wait_done(0, "ign_3x3", 32'd9, n);
        check("ign_latency", 32'(n), 32'(2));
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(bus4.DONE);
        end
        check("ign_one_done", 32'(cnt), 32'(0));

        // Back-to-back: START in the DONE cycle
        go(0, 0, 8'd2, 8'd3);
        wait_done(0, "b2b_2x3", 32'd6, n);
        bus4.START = 1'b1; bus4.A = 4'd4; bus4.B = 4'd4;
        @(negedge clk);
        bus4.START = 1'b0;
        n = 0;
        while (!bus4.DONE && n < 20) begin
            check("b2b_hold", 32'(bus4.Y), 32'd6);
            @(negedge clk);
            n++;
        end
        check("b2b_4x4", 32'(bus4.Y), 32'd16);

        // WIDTH=8
        go(1, 0, 8'd255, 8'd255); wait_done(1, "u8_255x255", 32'd65025, n);

        // Reset mid-run discards the operation
        go(1, 0, 8'd200, 8'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_busy8", 32'(bus8.BUSY), 32'(0));
        check("mr_done8", 32'(bus8.DONE), 32'(0));
        check("mr_y8",    32'(bus8.Y),    32'(0));
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(bus8.DONE);
        end
        check("mr_no_done", 32'(cnt), 32'(0));

        go(1, 1, 8'h80, 8'h80); wait_done(1, "s8_m128xm128", 32'd16384, n);
        go(1, 1, 8'hFD, 8'd5);  wait_done(1, "s8_m3x5",      32'hFFF1, n);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
